// File: rtl/cu_pkg.sv
// Shared compute-unit definitions for the shifter writeback/status stage.
//   CU_DATASIZE / CU_RFADDR : default result width and register-file index width
//   CU_WB_DEPTH             : default writeback buffer depth
//   wb_entry_t              : one pending writeback {addr, data}
//   ASTAT_*                 : bit positions of the shifter bits in the status vector
package cu_pkg;

    localparam int CU_DATASIZE = 16;
    localparam int CU_RFADDR   = 4;
    localparam int CU_WB_DEPTH = 2;

    typedef struct packed {
        logic [CU_RFADDR-1:0]   addr;
        logic [CU_DATASIZE-1:0] data;
    } wb_entry_t;

    localparam int ASTAT_SV = 0;
    localparam int ASTAT_SZ = 1;
    localparam int ASTAT_SS = 2;
    localparam int ASTAT_W  = 3;

endpackage

// File: rtl/shf_wb_fifo.sv
// Generic DEPTH-entry synchronous FIFO with per-entry peek.
//   clk, reset        : clock, synchronous active-high reset (discards contents)
//   push, push_data   : write an entry at the clock edge
//   pop               : drop the head entry at the clock edge (caller keeps it legal)
//   head, count, empty: oldest entry, occupancy, empty flag
//   peek[k], peek_v[k]: entry k positions after the head (k=0 oldest) and its valid bit
module shf_wb_fifo #(
    parameter int W     = 20,
    parameter int DEPTH = 2,
    localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic [W-1:0]  push_data,
    input  logic          pop,
    output logic [W-1:0]  head,
    output logic [AW:0]   count,
    output logic          empty,
    output logic [W-1:0]  peek [DEPTH],
    output logic [DEPTH-1:0] peek_v
);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] rd_ptr_reg;
    logic [AW-1:0] wr_ptr_reg;
    logic [AW:0]   count_reg;

    // Pointers are exactly log2(DEPTH) bits, so increment wraps modulo DEPTH.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
            case ({push, pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    // Storage carries no reset; occupancy alone decides what is valid.
    // Push+pop on a full buffer writes the slot being released this edge.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_reg] <= push_data;
    end

    assign head  = mem[rd_ptr_reg];
    assign count = count_reg;
    assign empty = (count_reg == '0);

    // Entries presented in age order so the consumer can pick the youngest match.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_peek
            logic [AW-1:0] idx;
            assign idx        = rd_ptr_reg + AW'(gi);
            assign peek[gi]   = mem[idx];
            assign peek_v[gi] = (count_reg > (AW+1)'(gi));
        end
    endgenerate

endmodule

// File: rtl/shf_wb_stat.sv
// Shifter writeback and status stage.
// Captures the shifter result one cycle after issue, buffers it with its
// destination index, drains it into the register-file write port when free,
// keeps ASTAT SV/SZ and sticky SV, and forwards pending results.
//   ps_shf_en/ps_shf_rd        : issue strobe and destination register
//   shf_xb_dt/shf_ps_sv/_sz    : shifter result and flags, valid the cycle after issue
//   rf_wp_busy                 : write port taken by another unit
//   ps_stky_clr                : clear sticky overflow
//   ps_rd_x/ps_rd_y            : operand read indices to check for forwarding
//   wb_rf_we/_addr/_dt         : register-file write port
//   wb_ps_full                 : sequencer must not issue
//   wb_fwd_x_hit/_y_hit/_dt    : forwarding result
//   wb_ps_sv/_sz/_ss           : ASTAT shifter bits
module shf_wb_stat
    import cu_pkg::*;
#(
    parameter int DATASIZE = CU_DATASIZE,
    parameter int RFADDR   = CU_RFADDR,
    parameter int DEPTH    = CU_WB_DEPTH
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                ps_shf_en,
    input  logic [RFADDR-1:0]   ps_shf_rd,
    input  logic [DATASIZE-1:0] shf_xb_dt,
    input  logic                shf_ps_sv,
    input  logic                shf_ps_sz,
    input  logic                rf_wp_busy,
    input  logic                ps_stky_clr,
    input  logic [RFADDR-1:0]   ps_rd_x,
    input  logic [RFADDR-1:0]   ps_rd_y,
    output logic                wb_rf_we,
    output logic [RFADDR-1:0]   wb_rf_addr,
    output logic [DATASIZE-1:0] wb_rf_dt,
    output logic                wb_ps_full,
    output logic                wb_fwd_x_hit,
    output logic                wb_fwd_y_hit,
    output logic [DATASIZE-1:0] wb_fwd_dt,
    output logic                wb_ps_sv,
    output logic                wb_ps_sz,
    output logic                wb_ps_ss
);

    localparam int EW = RFADDR + DATASIZE;
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;

    logic                iss_v_reg;
    logic [RFADDR-1:0]   iss_rd_reg;
    logic [ASTAT_W-1:0]  astat_reg;

    logic [EW-1:0]       head;
    logic [CW-1:0]       count;
    logic                empty;
    logic [EW-1:0]       peek [DEPTH];
    logic [DEPTH-1:0]    peek_v;
    logic                pop;

    shf_wb_fifo #(
        .W     (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (iss_v_reg),
        .push_data ({iss_rd_reg, shf_xb_dt}),
        .pop       (pop),
        .head      (head),
        .count     (count),
        .empty     (empty),
        .peek      (peek),
        .peek_v    (peek_v)
    );

    // No write may escape while reset is discarding the buffer.
    assign pop        = ~reset & ~empty & ~rf_wp_busy;
    assign wb_rf_we   = pop;
    assign wb_rf_addr = empty ? '0 : head[EW-1:DATASIZE];
    assign wb_rf_dt   = empty ? '0 : head[DATASIZE-1:0];

    // DEPTH-1 already counts as full because one op may still sit in iss_v.
    assign wb_ps_full = (count == CW'(DEPTH - 1)) |
                        ((count == CW'(DEPTH)) & ~pop);

    always_ff @(posedge clk) begin
        if (reset) begin
            iss_v_reg  <= 1'b0;
            iss_rd_reg <= '0;
            astat_reg  <= '0;
        end else begin
            iss_v_reg  <= ps_shf_en;
            iss_rd_reg <= ps_shf_rd;
            if (iss_v_reg) begin
                astat_reg[ASTAT_SV] <= shf_ps_sv;
                astat_reg[ASTAT_SZ] <= shf_ps_sz;
            end
            // A new overflow beats a coincident clear.
            if (iss_v_reg && shf_ps_sv)
                astat_reg[ASTAT_SS] <= 1'b1;
            else if (ps_stky_clr)
                astat_reg[ASTAT_SS] <= 1'b0;
        end
    end

    assign wb_ps_sv = astat_reg[ASTAT_SV];
    assign wb_ps_sz = astat_reg[ASTAT_SZ];
    assign wb_ps_ss = astat_reg[ASTAT_SS];

    // Forwarding: scan buffer oldest to youngest so later matches override,
    // then let the in-flight capture override everything.
    logic                x_hit, y_hit;
    logic [DATASIZE-1:0] x_dt, y_dt;

    always_comb begin
        x_hit = 1'b0;
        y_hit = 1'b0;
        x_dt  = '0;
        y_dt  = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if (peek_v[k] && (peek[k][EW-1:DATASIZE] == ps_rd_x)) begin
                x_hit = 1'b1;
                x_dt  = peek[k][DATASIZE-1:0];
            end
            if (peek_v[k] && (peek[k][EW-1:DATASIZE] == ps_rd_y)) begin
                y_hit = 1'b1;
                y_dt  = peek[k][DATASIZE-1:0];
            end
        end
        if (iss_v_reg && (iss_rd_reg == ps_rd_x)) begin
            x_hit = 1'b1;
            x_dt  = shf_xb_dt;
        end
        if (iss_v_reg && (iss_rd_reg == ps_rd_y)) begin
            y_hit = 1'b1;
            y_dt  = shf_xb_dt;
        end
    end

    assign wb_fwd_x_hit = x_hit;
    assign wb_fwd_y_hit = y_hit;
    assign wb_fwd_dt    = x_hit ? x_dt : (y_hit ? y_dt : '0);

endmodule

// File: doc/shf_wb_stat.md
Name: shf_wb_stat

Overview:
- Writeback and status stage directly downstream of the compute-unit shifter.
- Captures the shifter result and its SV/SZ flags one cycle after issue, tracks the destination register index alongside it, and queues the result in a 2-entry buffer.
- Drains the buffer into the register-file write port whenever that port is free.
- Maintains the shifter status bits (ASTAT SV/SZ, sticky SV) and exposes a forwarding path for pending results.

Parameters:
- DATASIZE, 16, data width of shifter result and register-file data.
- RFADDR, 4, width of register-file index (16 registers).
- DEPTH, 2, writeback buffer entries (power of two, at least 2).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- ps_shf_en  in  1  sequencer issues a shift op this cycle (same strobe the shifter samples).
- ps_shf_rd  in  RFADDR  destination register of the issued op.
- shf_xb_dt  in  DATASIZE  shifter result, valid the cycle after ps_shf_en.
- shf_ps_sv  in  1  shifter overflow flag, same timing as shf_xb_dt.
- shf_ps_sz  in  1  shifter zero flag, same timing as shf_xb_dt.
- rf_wp_busy  in  1  register-file write port claimed by another unit this cycle.
- ps_stky_clr  in  1  clear sticky overflow.
- ps_rd_x  in  RFADDR  operand-X read index, for forwarding.
- ps_rd_y  in  RFADDR  operand-Y read index, for forwarding.
- wb_rf_we  out  1  register-file write enable.
- wb_rf_addr  out  RFADDR  write index.
- wb_rf_dt  out  DATASIZE  write data.
- wb_ps_full  out  1  buffer cannot accept a further issue; sequencer must hold ps_shf_en low.
- wb_fwd_x_hit  out  1  ps_rd_x matches the newest pending entry.
- wb_fwd_y_hit  out  1  ps_rd_y matches the newest pending entry.
- wb_fwd_dt  out  DATASIZE  data of the newest pending matching entry.
- wb_ps_sv  out  1  ASTAT shifter overflow.
- wb_ps_sz  out  1  ASTAT shifter zero.
- wb_ps_ss  out  1  sticky shifter overflow.

Behaviour:
- Reset: all outputs 0, buffer empty, pointers 0, issue pipeline register cleared.
- Issue tracking: ps_shf_en and ps_shf_rd are registered into iss_v/iss_rd. When iss_v=1, shf_xb_dt, shf_ps_sv and shf_ps_sz are valid that cycle.
- Capture: in any cycle with iss_v=1, the entry {iss_rd, shf_xb_dt} is pushed at the clock edge.
- Flags on capture, same edge:
  - wb_ps_sv <= shf_ps_sv.
  - wb_ps_sz <= shf_ps_sz.
  - wb_ps_ss <= wb_ps_ss | shf_ps_sv.
- Flags otherwise hold their value.
- Sticky clear: ps_stky_clr clears wb_ps_ss. If a capture with sv=1 occurs in the same cycle, set wins and wb_ps_ss=1.
- Drain: wb_rf_we = (not empty) & ~rf_wp_busy, combinational. wb_rf_addr and wb_rf_dt always show the head entry, and are 0 when empty. Pop happens at the edge when wb_rf_we=1.
- Latency: issue at T, capture at end of T+1, earliest RF write in T+2.
- Ordering: entries write strictly in capture order.
- Simultaneous push and pop: allowed in every state including full; count is unchanged.
- wb_ps_full = (count == DEPTH-1) | (count == DEPTH & ~wb_rf_we).
  - This covers the one op in flight in iss_v.
  - A push into a full, non-popping buffer can therefore never be legal. The bench asserts it never occurs.
- Forwarding:
  - Search pending entries plus the in-flight capture, if iss_v=1.
  - Priority: newest first, i.e. the iss_v capture, then the youngest buffer entry.
  - A hit selects that entry's data onto wb_fwd_dt.
  - If X and Y both hit different entries, wb_fwd_dt follows X; Y forwarding then relies on the sequencer stalling.
  - wb_fwd_dt = 0 when there is no hit.
- Pointer wrap: read/write pointers are log2(DEPTH) bits and wrap modulo DEPTH. Count is log2(DEPTH)+1 bits.
- Reset mid-operation: buffered and in-flight entries are discarded with no RF write. Flags and sticky clear to 0.

Decomposition:
- Shared cu_pkg:
  - DATASIZE and RFADDR constants.
  - Writeback entry struct {addr, data}.
  - ASTAT bit positions for SV/SZ/SS.
- One sub-module, shf_wb_fifo: generic DEPTH-entry synchronous FIFO with push/pop/count and per-entry peek for the forwarding compare.
- Flag and forward logic stays in shf_wb_stat.

Test Plan:
- Single op: ps_shf_en with rd=3, then 16'h00F0 and sv=0 sz=0 one cycle later, rf_wp_busy=0.
  - Expect wb_rf_we=1, addr=3, dt=16'h00F0 in T+2, then empty.
  - Expect wb_ps_sv=0, wb_ps_sz=0.
- Back-to-back ops with rf_wp_busy held high for 4 cycles: rd=1/dt=16'h1111 then rd=2/dt=16'h2222.
  - wb_ps_full asserts after the second issue.
  - On release, writes occur in order 1 then 2 on consecutive cycles.
- Sticky overflow:
  - Op with sv=1, then op with sv=0: wb_ps_sv goes 1→0 while wb_ps_ss stays 1.
  - ps_stky_clr → wb_ps_ss=0.
  - ps_stky_clr coincident with an sv=1 capture → wb_ps_ss=1.
- Zero flag: result 16'h0000 with sz=1 → wb_ps_sz=1 and the RF write of 0 still occurs.
- Forwarding: pending rd=5/dt=16'hA5A5 with busy=1, and ps_rd_x=5, ps_rd_y=7.
  - Expect wb_fwd_x_hit=1, wb_fwd_y_hit=0, wb_fwd_dt=16'hA5A5.
  - Newer rd=5/dt=16'h0001 captured → wb_fwd_dt=16'h0001.
- Reset with 2 pending entries: assert reset for one cycle → no wb_rf_we afterwards, all flags 0, wb_ps_full=0.
